// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch-stage state encoding.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          INSN_BYTES = 4;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, inst} buffer between instruction memory and the IF/ID register.
module fetch_hold_buf
    import pipeline_pkg::*;
#(
    parameter int PC_WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_pc,
    input  logic [31:0]         load_inst,
    input  logic                consume,
    input  logic                clear,
    output logic [PC_WIDTH-1:0] hold_pc,
    output logic [31:0]         hold_inst,
    output logic                valid
);

    // clear beats load so a redirect never lets a stale word through
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= 1'b0;
            hold_pc   <= '0;
            hold_inst <= NOP_INSN;
        end else begin
            if (clear)        valid <= 1'b0;
            else if (load)    valid <= 1'b1;
            else if (consume) valid <= 1'b0;

            if (load && !clear) begin
                hold_pc   <= load_pc;
                hold_inst <= load_inst;
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single outstanding imem requests,
// buffers the returned word for IF/ID and handles EX redirects.
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter int                   PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req_valid,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_resp_valid,
    input  logic [31:0]         imem_resp_data,
    output logic [PC_WIDTH-1:0] PC_out,
    output logic [31:0]         instruction_out,
    output logic                inst_valid
);

    fetch_state_t        state, state_nx;
    logic [PC_WIDTH-1:0] pc_q, inflight_pc, redirect_tgt;
    logic [PC_WIDTH-1:0] hold_pc;
    logic [31:0]         hold_inst;
    logic                hold_valid, consume, hold_free;
    logic                req_hs, resp_load;

    assign redirect_tgt = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign consume      = hold_valid & ~stall;
    assign hold_free    = ~hold_valid | consume;
    assign req_hs       = imem_req_valid & imem_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= REQ;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_q;
        resp_load      = 1'b0;
        case (state)
            REQ: begin
                // only ask when the hold slot will be free for the answer
                imem_req_valid = hold_free & ~rst;
                if (redirect_valid)
                    state_nx = (imem_req_valid & imem_req_ready) ? DRAIN : REQ;
                else if (imem_req_valid & imem_req_ready)
                    state_nx = WAIT;
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    resp_load = ~redirect_valid;
                    state_nx  = REQ;
                end else if (redirect_valid) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_resp_valid) state_nx = REQ;
            end
            default: state_nx = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            inflight_pc <= '0;
        end else begin
            if (req_hs)
                inflight_pc <= pc_q;
            if (redirect_valid)
                pc_q <= redirect_tgt;
            else if (req_hs)
                pc_q <= pc_q + PC_WIDTH'(INSN_BYTES);
        end
    end

    fetch_hold_buf #(.PC_WIDTH(PC_WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (resp_load),
        .load_pc   (inflight_pc),
        .load_inst (imem_resp_data),
        .consume   (consume),
        .clear     (redirect_valid),
        .hold_pc   (hold_pc),
        .hold_inst (hold_inst),
        .valid     (hold_valid)
    );

    assign PC_out          = hold_pc;
    assign instruction_out = hold_valid ? hold_inst : NOP_INSN;
    assign inst_valid      = hold_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a request-queue reference model.
module tb_if_fetch_unit;

    localparam int          PC_WIDTH = 64;
    localparam logic [63:0] RST_PC   = 64'h1000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          N_CYC    = 2400;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                stall = 1'b0;
    logic                redirect_valid = 1'b0;
    logic [PC_WIDTH-1:0] redirect_pc = '0;
    logic                imem_req_valid;
    logic [PC_WIDTH-1:0] imem_req_addr;
    logic                imem_req_ready = 1'b0;
    logic                imem_resp_valid = 1'b0;
    logic [31:0]         imem_resp_data = '0;
    logic [PC_WIDTH-1:0] PC_out;
    logic [31:0]         instruction_out;
    logic                inst_valid;

    if_fetch_unit #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .inst_valid      (inst_valid)
    );

    always #5 clk = ~clk;

    // reference model: outstanding fetches with a "still wanted" flag, and the hold slot
    typedef struct {
        logic [63:0] addr;
        bit          live;
    } req_t;

    req_t        q[$];
    logic [63:0] m_pc;
    bit          m_hv;
    logic [63:0] m_hpc;
    logic [31:0] m_hinst;
    int          lat;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          exp_rv;
    bit          stale_inject = 0;
    bit          did_rst = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = RST_PC;
        m_hv = 0;
        lat  = 0;
    endtask

    task automatic check_outputs();
        exp_rv = (q.size() == 0) && (!m_hv || !stall);
        chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", 64'(inst_valid), 64'(m_hv));
        if (m_hv) begin
            chk("pc_out", PC_out, m_hpc);
            chk("instr", 64'(instruction_out), 64'(m_hinst));
        end else begin
            chk("instr_nop", 64'(instruction_out), 64'(NOP));
        end
    endtask

    task automatic model_step();
        bit          hs, rd, ld;
        logic [63:0] tgt;
        req_t        e;
        hs  = exp_rv && imem_req_ready;
        rd  = redirect_valid;
        tgt = {redirect_pc[63:2], 2'b00};
        ld  = 0;
        if (imem_resp_valid && q.size() > 0) begin
            e = q.pop_front();
            if (e.live && !rd) begin
                ld      = 1;
                m_hpc   = e.addr;
                m_hinst = imem_resp_data;
            end
        end
        if (rd)               m_hv = 0;
        else if (ld)          m_hv = 1;
        else if (m_hv && !stall) m_hv = 0;
        if (rd) foreach (q[i]) q[i].live = 0;
        if (hs) begin
            q.push_back('{addr: m_pc, live: !rd});
            lat = (cyc < 40) ? 0 : int'($urandom_range(0, 3));
        end else if (q.size() > 0 && lat > 0) begin
            lat--;
        end
        if (rd)      m_pc = tgt;
        else if (hs) m_pc = m_pc + 64'd4;
    endtask

    task automatic drive_inputs();
        int p_stall, p_rd, p_rdy;
        if (cyc < 40) begin
            p_stall = 0; p_rd = 0; p_rdy = 100;
        end else if (cyc < 800) begin
            p_stall = 25; p_rd = 10; p_rdy = 70;
        end else if (cyc < 1200) begin
            p_stall = 15; p_rd = 6; p_rdy = 20;
        end else begin
            p_stall = 30; p_rd = 12; p_rdy = 60;
        end
        stall          = ($urandom_range(0, 99) < p_stall);
        redirect_valid = ($urandom_range(0, 99) < p_rd);
        case ($urandom_range(0, 3))
            0:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            1:       redirect_pc = {$urandom, $urandom};
            default: redirect_pc = 64'h2000 + 64'($urandom_range(0, 255));
        endcase
        imem_req_ready  = ($urandom_range(0, 99) < p_rdy);
        imem_resp_valid = (q.size() > 0) && (lat == 0);
        imem_resp_data  = (q.size() > 0) ? mem_word(q[0].addr) : $urandom;
        if (stale_inject) begin
            // a late word from the fetch abandoned by reset
            stale_inject    = 0;
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
            imem_req_ready  = 1'b0;
            redirect_valid  = 1'b0;
        end
    endtask

    task automatic mid_reset();
        stall = 0; redirect_valid = 0; imem_req_ready = 0; imem_resp_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_instr", 64'(instruction_out), 64'(NOP));
        chk("rst_pc_out", PC_out, 64'd0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        model_reset();
        @(posedge clk); #1;
        chk("rst_req_hold", 64'(imem_req_valid), 64'd0);
        rst = 1'b0;
        stale_inject = 1;
    endtask

    initial begin
        model_reset();
        #1;
        chk("init_inst_valid", 64'(inst_valid), 64'd0);
        chk("init_instr", 64'(instruction_out), 64'(NOP));
        chk("init_pc_out", PC_out, 64'd0);
        chk("init_req_valid", 64'(imem_req_valid), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N_CYC; i++) begin
            cyc = i;
            if (!did_rst && i > 1300 && q.size() > 0) begin
                did_rst = 1;
                mid_reset();
            end
            drive_inputs();
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            model_step();
            #1;
        end
        if (!did_rst) chk("mid_reset_reached", 64'd0, 64'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
